csr_bank: RTL and testbench
===========================

# csr_bank

Parametrised control/status register bank for the TRNG datapath. It generalises the single byte-write register to NUM_REGS registers of WIDTH bits, each with a configurable byte-lane count. Every register has its own access mode:
- RW: software-owned.
- RO: sampled from hardware.
- W1C: sticky hardware event bits that software clears by writing 1.

The bank sits between the bus-side CSR decoder and the entropy source / health-test logic. It adds registered reads, a write lock and error reporting.

## Interface
Parameters:
- WIDTH, 32, register width in bits; must be a multiple of BYTE_W
- BYTE_W, 8, bits per write-strobe lane; NB = WIDTH/BYTE_W lanes
- NUM_REGS, 8, number of registers (≥2)
- ADDR_W, 3, address width; 2^ADDR_W ≥ NUM_REGS
- RO_MASK, 8'h00, bit r = 1 makes register r read-only (hardware-sampled)
- W1C_MASK, 8'h00, bit r = 1 makes register r write-1-to-clear; RO_MASK & W1C_MASK must be 0
- RESET_VAL, all-zero, packed NUM_REGS*WIDTH reset contents; register r occupies [r*WIDTH +: WIDTH]

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  write request
- wr_addr  in  ADDR_W  write register index
- wr_strb  in  NB  per-lane write enable
- wr_data  in  WIDTH  write data
- lock  in  1  when high, writes to RW registers are blocked
- wr_err  out  1  one-cycle pulse on a rejected write
- rd_en  in  1  read request
- rd_addr  in  ADDR_W  read register index
- rd_data  out  WIDTH  read data, registered
- rd_valid  out  1  one-cycle pulse, rd_data valid
- rd_err  out  1  with rd_valid: address out of range
- hw_data  in  NUM_REGS*WIDTH  sample source for RO registers (other slices ignored)
- hw_set  in  NUM_REGS*WIDTH  per-bit set pulses for W1C registers (other slices ignored)
- q  out  NUM_REGS*WIDTH  current contents of all registers

## Operation
- Clock is clk; reset is rst, synchronous and active-high. All state updates on the posedge of clk; rst has priority over every other input.
- Reset values:
  - q = RESET_VAL.
  - rd_data = 0, rd_valid = 0, rd_err = 0, wr_err = 0.
- RW register r, when wr_en, wr_addr == r and lock == 0: lane i is replaced by wr_data lane i for each wr_strb[i] = 1. Other lanes hold.
- RO register r: loads hw_data slice r every cycle, unconditionally. A bus write to it changes nothing and asserts wr_err.
- W1C register r:
  - Next value = (cur & ~clr) | set.
  - clr = wr_data bits within strobed lanes when wr_en and wr_addr == r; otherwise 0.
  - set = hw_set slice r.
  - If set and clear hit the same bit in the same cycle, set wins.
  - W1C clears are not affected by lock.
- wr_err asserts the cycle after any of these:
  - wr_en with wr_addr ≥ NUM_REGS;
  - wr_en to an RO register;
  - wr_en to an RW register while lock = 1.
- A rejected write modifies nothing.
- wr_en with wr_strb = 0 is a legal no-op and gives no wr_err.
- Reads, on rd_en:
  - The next cycle has rd_valid = 1.
  - rd_data = contents of rd_addr as they were before this edge. A same-cycle write is not visible; the old value is returned.
  - If rd_addr ≥ NUM_REGS: rd_data = 0 and rd_err = 1.
- rd_data holds its value when rd_valid = 0. rd_err = 0 whenever rd_valid = 0.
- Reads and writes are independent ports: both may fire every cycle, back-to-back, with no stall.

## Timing
- Write latency: 1 cycle. The value is visible on q at the edge that samples wr_en.
- Read latency: 1 cycle. rd_valid/rd_data/rd_err are registered.
- RO registers lag hw_data by 1 cycle. W1C sets appear on q 1 cycle after hw_set.
- wr_err is a 1-cycle pulse per rejected request. Consecutive rejected requests give consecutive pulses.
- rst asserted mid-operation: on the next edge, every register takes RESET_VAL and all outputs return to their reset values. A pending read is dropped (rd_valid = 0), and no write in that cycle takes effect.

## Test plan
- Reset → q = RESET_VAL. Reset with RESET_VAL reg0 = 32'hDEAD_BEEF → q[31:0] = 32'hDEADBEEF; rd_valid = 0, wr_err = 0.
- Byte-strobe write:
  - Reg1 = 32'h0000_0000; write 32'h1122_3344 with wr_strb = 4'b0101 → q reg1 = 32'h0022_0044.
  - Then read addr 1 → next cycle rd_valid = 1, rd_data = 32'h0022_0044.
- Read/write collision: reg2 = 32'hA5A5_A5A5; same cycle write 32'h0F0F_0F0F (strb 4'hF) and read addr 2 → rd_data = 32'hA5A5_A5A5; the next read returns 32'h0F0F_0F0F.
- W1C (W1C_MASK bit 3 set):
  - hw_set pulses bits 0 and 4 → reg3 = 32'h11.
  - Write 32'h01 → reg3 = 32'h10.
  - Same cycle hw_set bit 4 and write clear 32'h10 → reg3 stays 32'h10 (set wins).
- Lock/RO/range (RO_MASK bit 5 set):
  - lock = 1, write reg1 → unchanged, wr_err pulse.
  - Write reg5 → wr_err; reg5 tracks hw_data 32'hCAFE_0001 one cycle later.
  - Write addr 7 with NUM_REGS = 6 → wr_err; read addr 7 → rd_valid = 1, rd_err = 1, rd_data = 0.
- Reset mid-traffic: rd_en and wr_en asserted in the same cycle as rst → next cycle rd_valid = 0, q = RESET_VAL, wr_err = 0.

Source files
------------

// File: rtl/csr_bank.sv
// csr_bank: parametrised CSR bank with RW / RO / W1C registers, byte-lane
// strobes, write lock, registered reads and write/read error reporting.
module csr_bank #(
  parameter int                        WIDTH     = 32,
  parameter int                        BYTE_W    = 8,
  parameter int                        NUM_REGS  = 8,
  parameter int                        ADDR_W    = 3,
  parameter logic [NUM_REGS-1:0]       RO_MASK   = '0,
  parameter logic [NUM_REGS-1:0]       W1C_MASK  = '0,
  parameter logic [NUM_REGS*WIDTH-1:0] RESET_VAL = '0,
  localparam int                       NB        = WIDTH / BYTE_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [ADDR_W-1:0]         wr_addr,
  input  logic [NB-1:0]             wr_strb,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic                      lock,
  output logic                      wr_err,
  input  logic                      rd_en,
  input  logic [ADDR_W-1:0]         rd_addr,
  output logic [WIDTH-1:0]          rd_data,
  output logic                      rd_valid,
  output logic                      rd_err,
  input  logic [NUM_REGS*WIDTH-1:0] hw_data,
  input  logic [NUM_REGS*WIDTH-1:0] hw_set,
  output logic [NUM_REGS*WIDTH-1:0] q
);

  logic [WIDTH-1:0] strb_mask;
  logic             wr_in_range;
  logic             wr_blocked;
  logic             wr_reject;
  logic             rd_in_range;
  logic [WIDTH-1:0] rd_mux;

  // Only the RO slices of hw_data and the W1C slices of hw_set are consumed.
  logic unused_hw;
  assign unused_hw = ^{hw_data, hw_set};

  always_comb begin
    strb_mask = '0;
    for (int i = 0; i < NB; i++) begin
      strb_mask[i*BYTE_W +: BYTE_W] = {BYTE_W{wr_strb[i]}};
    end
  end

  always_comb begin
    wr_in_range = 1'b0;
    wr_blocked  = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (wr_addr == ADDR_W'(r)) begin
        wr_in_range = 1'b1;
        wr_blocked  = RO_MASK[r] | (~W1C_MASK[r] & lock);
      end
    end
  end

  // An all-zero strobe is a legal no-op even on an otherwise illegal target.
  assign wr_reject = wr_en & (|wr_strb) & (~wr_in_range | wr_blocked);

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
    logic wr_hit;
    assign wr_hit = wr_en && (wr_addr == ADDR_W'(r));

    if (RO_MASK[r]) begin : g_ro
      always_ff @(posedge clk) begin
        if (rst) q[r*WIDTH +: WIDTH] <= RESET_VAL[r*WIDTH +: WIDTH];
        else     q[r*WIDTH +: WIDTH] <= hw_data[r*WIDTH +: WIDTH];
      end
    end else if (W1C_MASK[r]) begin : g_w1c
      logic [WIDTH-1:0] clr;
      assign clr = wr_hit ? (wr_data & strb_mask) : '0;
      always_ff @(posedge clk) begin
        if (rst) q[r*WIDTH +: WIDTH] <= RESET_VAL[r*WIDTH +: WIDTH];
        else     q[r*WIDTH +: WIDTH] <= (q[r*WIDTH +: WIDTH] & ~clr) | hw_set[r*WIDTH +: WIDTH];
      end
    end else begin : g_rw
      always_ff @(posedge clk) begin
        if (rst) begin
          q[r*WIDTH +: WIDTH] <= RESET_VAL[r*WIDTH +: WIDTH];
        end else if (wr_hit && !lock) begin
          q[r*WIDTH +: WIDTH] <= (q[r*WIDTH +: WIDTH] & ~strb_mask) | (wr_data & strb_mask);
        end
      end
    end
  end

  always_comb begin
    rd_in_range = 1'b0;
    rd_mux      = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (rd_addr == ADDR_W'(r)) begin
        rd_in_range = 1'b1;
        rd_mux      = q[r*WIDTH +: WIDTH];
      end
    end
  end

  // Reads sample q before this edge, so a same-cycle write returns old data.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
      wr_err   <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      rd_err   <= rd_en & ~rd_in_range;
      wr_err   <= wr_reject;
      if (rd_en) rd_data <= rd_in_range ? rd_mux : '0;
    end
  end

endmodule

// File: tb/tb_csr_bank.sv
// Self-checking bench for csr_bank: directed writes plus a read scoreboard
// whose monitor pops an expected response on every rd_valid.
module tb_csr_bank;
  localparam int W  = 32;
  localparam int N  = 6;
  localparam int AW = 3;
  localparam logic [N*W-1:0] RST_V = {{(N-1)*W{1'b0}}, 32'hDEAD_BEEF};

  logic           clk = 1'b0;
  logic           rst;
  logic           wr_en;
  logic [AW-1:0]  wr_addr;
  logic [3:0]     wr_strb;
  logic [W-1:0]   wr_data;
  logic           lock;
  logic           wr_err;
  logic           rd_en;
  logic [AW-1:0]  rd_addr;
  logic [W-1:0]   rd_data;
  logic           rd_valid;
  logic           rd_err;
  logic [N*W-1:0] hw_data;
  logic [N*W-1:0] hw_set;
  logic [N*W-1:0] q;

  typedef struct { logic [W-1:0] data; logic err; } rd_exp_t;
  rd_exp_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  csr_bank #(
    .WIDTH(W), .BYTE_W(8), .NUM_REGS(N), .ADDR_W(AW),
    .RO_MASK(6'b100000), .W1C_MASK(6'b001000), .RESET_VAL(RST_V)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_strb(wr_strb), .wr_data(wr_data),
    .lock(lock), .wr_err(wr_err),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_err(rd_err),
    .hw_data(hw_data), .hw_set(hw_set), .q(q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] qr(input int r);
    return q[r*W +: W];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [3:0] s, input logic [W-1:0] d);
    wr_en = 1'b1; wr_addr = AW'(a); wr_strb = s; wr_data = d;
  endtask

  task automatic rd(input int a, input logic [W-1:0] d, input logic e);
    rd_exp_t x;
    rd_en = 1'b1; rd_addr = AW'(a);
    x.data = d; x.err = e;
    exp_q.push_back(x);
  endtask

  task automatic idle();
    wr_en = 1'b0; rd_en = 1'b0; wr_strb = '0; hw_set = '0;
  endtask

  // Monitor: every presented read response is matched against the scoreboard.
  initial begin
    rd_exp_t e;
    forever begin
      @(negedge clk);
      if (rd_valid) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL rd_unexpected: got rd_valid=1 expected no response");
        end else begin
          e = exp_q.pop_front();
          chk("rd_data", rd_data, e.data);
          chk("rd_err", rd_err, e.err);
        end
      end else if (rd_err) begin
        n_tests++; n_fail++;
        $display("FAIL rd_err_idle: got rd_err=1 expected 0 without rd_valid");
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; lock = 1'b0; hw_data = '0; wr_addr = '0; wr_data = '0;
    rd_addr = '0; idle();
    tick();
    chk("reset q", q, RST_V);
    chk("reset reg0", qr(0), 32'hDEAD_BEEF);
    chk("reset rd_valid", rd_valid, 0);
    chk("reset wr_err", wr_err, 0);
    rst = 1'b0;

    // Byte-strobe write then read back.
    wr(1, 4'b0101, 32'h1122_3344); tick(); idle();
    chk("strb reg1", qr(1), 32'h0022_0044);
    chk("strb wr_err", wr_err, 0);
    rd(1, 32'h0022_0044, 1'b0); tick(); idle();

    // Read/write collision returns old value.
    wr(2, 4'hF, 32'hA5A5_A5A5); tick(); idle();
    wr(2, 4'hF, 32'h0F0F_0F0F); rd(2, 32'hA5A5_A5A5, 1'b0); tick(); idle();
    rd(2, 32'h0F0F_0F0F, 1'b0); tick(); idle();
    chk("collision reg2", qr(2), 32'h0F0F_0F0F);

    // W1C register 3.
    hw_set[3*W +: W] = 32'h11; tick(); idle();
    chk("w1c set", qr(3), 32'h11);
    wr(3, 4'hF, 32'h01); tick(); idle();
    chk("w1c clr", qr(3), 32'h10);
    chk("w1c wr_err", wr_err, 0);
    wr(3, 4'hF, 32'h10); hw_set[3*W +: W] = 32'h10; tick(); idle();
    chk("w1c set wins", qr(3), 32'h10);
    wr(3, 4'b1110, 32'h10); tick(); idle();
    chk("w1c unstrobed", qr(3), 32'h10);
    wr(3, 4'b0001, 32'h10); tick(); idle();
    chk("w1c clr2", qr(3), 32'h0);
    hw_set[3*W +: W] = 32'h02; tick(); idle();
    lock = 1'b1; wr(3, 4'hF, 32'h02); tick(); idle();
    chk("w1c locked clr", qr(3), 32'h0);
    chk("w1c locked wr_err", wr_err, 0);

    // Lock on RW, then RO write back-to-back: consecutive pulses.
    wr(1, 4'hF, 32'hFFFF_FFFF); tick();
    chk("lock reg1", qr(1), 32'h0022_0044);
    chk("lock wr_err", wr_err, 1);
    lock = 1'b0;
    hw_data[5*W +: W] = 32'hCAFE_0001;
    wr(5, 4'hF, 32'h1234_5678); tick(); idle();
    chk("ro wr_err", wr_err, 1);
    chk("ro reg5", qr(5), 32'hCAFE_0001);
    wr(1, 4'h0, 32'hFFFF_FFFF); lock = 1'b1; tick(); idle(); lock = 1'b0;
    chk("zero strb wr_err", wr_err, 0);
    chk("zero strb reg1", qr(1), 32'h0022_0044);
    wr(7, 4'hF, 32'hFFFF_FFFF); tick(); idle();
    chk("range wr_err", wr_err, 1);
    chk("range q", q, {32'hCAFE_0001, 32'h0, 32'h0, 32'h0F0F_0F0F, 32'h0022_0044, 32'hDEAD_BEEF});
    tick();
    chk("wr_err pulse end", wr_err, 0);

    // Back-to-back reads including out-of-range.
    rd(7, 32'h0, 1'b1); tick();
    rd(5, 32'hCAFE_0001, 1'b0); tick();
    rd(0, 32'hDEAD_BEEF, 1'b0); tick(); idle();
    tick();

    // Reset mid-traffic.
    rst = 1'b1; rd_en = 1'b1; rd_addr = AW'(1); wr(1, 4'hF, 32'hFFFF_FFFF);
    tick(); idle(); rst = 1'b0;
    chk("midrst rd_valid", rd_valid, 0);
    chk("midrst rd_data", rd_data, 0);
    chk("midrst wr_err", wr_err, 0);
    chk("midrst q", q, RST_V);
    tick();
    chk("post rst reg5", qr(5), 32'hCAFE_0001);
    chk("rd queue drained", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
